// File: rtl/gpio_in_pkg.sv
// ---------------------------------------------------------------------------
// gpio_in_pkg
// Shared types and constants for the GPIO nibble conditioner.
//   gpio_state_t           : debounce FSM states (ST_STABLE, ST_SETTLE)
//   GPIO_CNT_W             : width of the stability counter
//   GPIO_DEFAULT_DEBOUNCE  : default stable-clock count (10 ms at 50 MHz)
// ---------------------------------------------------------------------------
package gpio_in_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } gpio_state_t;

    localparam int GPIO_CNT_W            = 24;
    localparam int GPIO_DEFAULT_DEBOUNCE = 500000;

endpackage : gpio_in_pkg

// File: rtl/gpio_sync2.sv
// ---------------------------------------------------------------------------
// gpio_sync2
// WIDTH-bit two-flop synchroniser; every bit is sampled in parallel.
// Ports:
//   clk      in          : destination clock
//   reset_n  in          : synchronous, active-low reset (clears both stages)
//   d        in  [W-1:0] : asynchronous input bits
//   q        out [W-1:0] : synchronised bits (second stage)
// ---------------------------------------------------------------------------
module gpio_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule : gpio_sync2

// File: rtl/gpio_nibble_debounce.sv
// ---------------------------------------------------------------------------
// gpio_nibble_debounce
// Synchronises raw GPIO header bits and debounces them as one group, then
// presents a stable registered value plus one-cycle change/edge strobes.
//
// Optional feature macro: GPIO_DEBOUNCE_CHANGE_COUNT_EN
//   defined   -> change_count port and an 8-bit wrapping commit counter exist
//   undefined -> port and register are absent; everything else is identical
//
// Ports:
//   clk           in          : system clock
//   reset_n       in          : synchronous, active-low reset
//   gpio_in       in  [W-1:0] : raw asynchronous header bits
//   data_out      out [W-1:0] : debounced value
//   change_pulse  out         : one-cycle strobe when data_out updates
//   rise_mask     out [W-1:0] : bits that went 0->1 on this commit
//   fall_mask     out [W-1:0] : bits that went 1->0 on this commit
//   change_count  out [7:0]   : commit counter (macro builds only)
//
// Strobe semantics: change_pulse is a qualifier with no back-pressure; the
// masks carry meaning only in the cycle change_pulse is high and read 0
// otherwise. Consumers must sample them in that same cycle.
//
// The FSM state is kept in the named signal 'state' so checkers can bind to it.
// ---------------------------------------------------------------------------
module gpio_nibble_debounce
    import gpio_in_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = GPIO_DEFAULT_DEBOUNCE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] data_out,
    output logic             change_pulse,
    output logic [WIDTH-1:0] rise_mask,
    output logic [WIDTH-1:0] fall_mask
`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
    ,
    output logic [7:0]       change_count
`endif
);

    // Counter value at which the candidate has been seen DEBOUNCE_CYCLES times.
    localparam logic [GPIO_CNT_W-1:0] CNT_LAST = GPIO_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]      sync2;
    logic [WIDTH-1:0]      candidate;
    logic [GPIO_CNT_W-1:0] cnt;
    gpio_state_t           state;

    gpio_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (gpio_in),
        .q       (sync2)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_STABLE;
            candidate    <= '0;
            cnt          <= '0;
            data_out     <= '0;
            change_pulse <= 1'b0;
            rise_mask    <= '0;
            fall_mask    <= '0;
`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
            change_count <= 8'd0;
`endif
        end else begin
            // Strobes default low; only a commit raises them for one cycle.
            change_pulse <= 1'b0;
            rise_mask    <= '0;
            fall_mask    <= '0;

            case (state)
                ST_STABLE: begin
                    if (sync2 != data_out) begin
                        candidate <= sync2;
                        cnt       <= GPIO_CNT_W'(1);
                        state     <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (sync2 == data_out) begin
                        // Input fell back to the committed value: glitch dropped.
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else if (sync2 != candidate) begin
                        // Any bit moving restarts the whole group.
                        candidate <= sync2;
                        cnt       <= GPIO_CNT_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        data_out     <= candidate;
                        change_pulse <= 1'b1;
                        rise_mask    <= candidate & ~data_out;
                        fall_mask    <= ~candidate & data_out;
                        cnt          <= '0;
                        state        <= ST_STABLE;
`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
                        change_count <= change_count + 8'd1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= ST_STABLE;
                end
            endcase
        end
    end

endmodule : gpio_nibble_debounce

// File: tb/tb_gpio_nibble_debounce.sv
module tb_gpio_nibble_debounce;

    localparam int W = 4;
    localparam int D = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] data_out;
    logic         change_pulse;
    logic [W-1:0] rise_mask;
    logic [W-1:0] fall_mask;
`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
    logic [7:0]   change_count;
`endif

    always #5 clk = ~clk;

    gpio_nibble_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gpio_in      (gpio_in),
        .data_out     (data_out),
        .change_pulse (change_pulse),
        .rise_mask    (rise_mask),
        .fall_mask    (fall_mask)
`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
        ,
        .change_count (change_count)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Rule: the pins reach the decision point two clocks late. The committed
    // value follows a value v != committed once v has been seen on D
    // consecutive clocks at that point; the strobe lasts the commit cycle only.
    logic [W-1:0] m_delay[2];
    logic [W-1:0] m_seen;
    logic [W-1:0] m_last;
    int           m_run;
    logic [W-1:0] m_data;
    logic         m_pulse;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    int           m_count;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_delay[0] = '0;
            m_delay[1] = '0;
            m_last     = '0;
            m_run      = 0;
            m_data     = '0;
            m_pulse    = 1'b0;
            m_rise     = '0;
            m_fall     = '0;
            m_count    = 0;
            m_valid    = 1'b1;
        end else begin
            m_seen     = m_delay[1];
            m_delay[1] = m_delay[0];
            m_delay[0] = gpio_in;
            m_run      = (m_seen == m_last) ? m_run + 1 : 1;
            m_last     = m_seen;
            m_pulse    = 1'b0;
            m_rise     = '0;
            m_fall     = '0;
            if (m_seen != m_data && m_run == D) begin
                m_rise  = m_seen & ~m_data;
                m_fall  = ~m_seen & m_data;
                m_data  = m_seen;
                m_pulse = 1'b1;
                m_count = (m_count + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model data_out", 32'(data_out), 32'(m_data));
            check("model change_pulse", 32'(change_pulse), 32'(m_pulse));
            check("model rise_mask", 32'(rise_mask), 32'(m_rise));
            check("model fall_mask", 32'(fall_mask), 32'(m_fall));
`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
            check("model change_count", 32'(change_count), 32'(m_count));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Advances n clock edges; inputs change only #1 after an edge.
    task automatic run_edges(input int n, output int pulses, output int first_e,
                             output logic [W-1:0] r, output logic [W-1:0] f);
        pulses  = 0;
        first_e = 0;
        r       = '0;
        f       = '0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (change_pulse) begin
                pulses++;
                if (first_e == 0) begin
                    first_e = e;
                    r       = rise_mask;
                    f       = fall_mask;
                end
            end
        end
    endtask

    task automatic do_reset();
        int p, fe;
        logic [W-1:0] r, f;
        reset_n = 1'b0;
        gpio_in = '0;
        run_edges(2, p, fe, r, f);
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset change_pulse", 32'(change_pulse), 32'h0);
        check("reset rise_mask", 32'(rise_mask), 32'h0);
        check("reset fall_mask", 32'(fall_mask), 32'h0);
        reset_n = 1'b1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [W-1:0] val;
        int           hold;
        logic [W-1:0] exp_data;
        int           exp_pulses;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int p, fe, p2, fe2;
        logic [W-1:0] r, f, r2, f2;
        logic [W-1:0] v;

        vecs[0] = '{4'h5, 12, 4'h5, 1};
        vecs[1] = '{4'h3,  5, 4'h5, 0};
        vecs[2] = '{4'h5, 12, 4'h5, 0};
        vecs[3] = '{4'hA,  9, 4'h5, 0};
        vecs[4] = '{4'hA,  1, 4'hA, 1};
        vecs[5] = '{4'hF, 10, 4'hF, 1};
        vecs[6] = '{4'h0,  7, 4'hF, 0};
        vecs[7] = '{4'hF, 12, 4'hF, 0};
        vecs[8] = '{4'h0, 10, 4'h0, 1};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            gpio_in = vecs[i].val;
            run_edges(vecs[i].hold, p, fe, r, f);
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d pulses", i), 32'(p), 32'(vecs[i].exp_pulses));
        end

        // Clean change 0 -> 5: commit on edge 10 only.
        do_reset();
        gpio_in = 4'h5;
        run_edges(14, p, fe, r, f);
        check("clean pulses", 32'(p), 32'd1);
        check("clean edge", 32'(fe), 32'd10);
        check("clean data", 32'(data_out), 32'h5);
        check("clean rise", 32'(r), 32'h5);
        check("clean fall", 32'(f), 32'h0);

        // Glitch of 5 clocks never reaches the output.
        do_reset();
        gpio_in = 4'h3;
        run_edges(5, p, fe, r, f);
        gpio_in = 4'h0;
        run_edges(15, p2, fe2, r2, f2);
        check("glitch pulses", 32'(p + p2), 32'd0);
        check("glitch data", 32'(data_out), 32'h0);

        // Bounce 9/1/9: single commit 10 edges after the last transition.
        do_reset();
        gpio_in = 4'h9;
        run_edges(4, p, fe, r, f);
        gpio_in = 4'h1;
        run_edges(3, p2, fe2, r2, f2);
        check("bounce early pulses", 32'(p + p2), 32'd0);
        gpio_in = 4'h9;
        run_edges(14, p, fe, r, f);
        check("bounce pulses", 32'(p), 32'd1);
        check("bounce edge", 32'(fe), 32'd10);
        check("bounce rise", 32'(r), 32'h9);
        check("bounce fall", 32'(f), 32'h0);
        check("bounce data", 32'(data_out), 32'h9);

        // Multi-bit fall F -> A.
        do_reset();
        gpio_in = 4'hF;
        run_edges(12, p, fe, r, f);
        check("mfall setup data", 32'(data_out), 32'hF);
        gpio_in = 4'hA;
        run_edges(12, p, fe, r, f);
        check("mfall pulses", 32'(p), 32'd1);
        check("mfall edge", 32'(fe), 32'd10);
        check("mfall rise", 32'(r), 32'h0);
        check("mfall fall", 32'(f), 32'h5);
        check("mfall data", 32'(data_out), 32'hA);

        // Reset mid-SETTLE abandons the candidate.
        do_reset();
        gpio_in = 4'h7;
        run_edges(4, p, fe, r, f);
        check("rstmid early pulses", 32'(p), 32'd0);
        reset_n = 1'b0;
        run_edges(1, p, fe, r, f);
        check("rstmid pulses in reset", 32'(p), 32'd0);
        check("rstmid data", 32'(data_out), 32'h0);
        check("rstmid rise", 32'(rise_mask), 32'h0);
        check("rstmid fall", 32'(fall_mask), 32'h0);
        reset_n = 1'b1;
        run_edges(14, p, fe, r, f);
        check("rstmid commit pulses", 32'(p), 32'd1);
        check("rstmid commit edge", 32'(fe), 32'd10);
        check("rstmid commit data", 32'(data_out), 32'h7);

        // Random stimulus, checked continuously by the model.
        do_reset();
        v = '0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) != 0)
                v = W'($urandom_range(0, 15));
            gpio_in = v;
            run_edges($urandom_range(1, 14), p, fe, r, f);
        end

`ifdef GPIO_DEBOUNCE_CHANGE_COUNT_EN
        // Counter wrap: 256 alternating commits.
        do_reset();
        check("count reset", 32'(change_count), 32'd0);
        for (int i = 1; i <= 256; i++) begin
            gpio_in = (i % 2 == 1) ? 4'h1 : 4'h0;
            run_edges(11, p, fe, r, f);
            if (i == 255)
                check("count at 255", 32'(change_count), 32'd255);
            if (i == 256)
                check("count wrap", 32'(change_count), 32'd0);
        end
`endif

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gpio_nibble_debounce
